// File: rtl/regfile_dump_reader_pkg.sv
// Shared definitions for the register-file dump reader.
//   XLEN     : width of one architectural register
//   AW       : register index width
//   NUM_REGS : number of registers in the file
//   state_e  : reader FSM state encoding
package regfile_dump_reader_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned AW       = 5;
    localparam int unsigned NUM_REGS = 32;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StFetch  = 2'd1,
        StSend   = 2'd2,
        StFinish = 2'd3
    } state_e;

endpackage

// File: rtl/regfile_dump_reader.sv
// Walks an inclusive index range of the register file through one combinational read port and
// streams (index, value, last) words over a valid/ready interface.
//
// Ports:
//   clk, rst              clock; asynchronous active-high reset
//   start                 one-cycle dump request, honoured only when idle
//   first_idx, last_idx   inclusive index range, captured when start is accepted
//   abort                 drop an active dump and return to idle without a done pulse
//   rf_raddr / rf_rdata   dedicated register-file read port (address out, data in)
//   out_valid/out_ready   stream handshake; out_idx, out_data, out_last carry the word
//   busy                  reader is not idle
//   done                  one-cycle pulse when a dump completes (also on a rejected range)
//   range_err             one-cycle pulse when start is accepted with first_idx > last_idx
module regfile_dump_reader
    import regfile_dump_reader_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [AW-1:0]   first_idx,
    input  logic [AW-1:0]   last_idx,
    input  logic            abort,
    output logic [AW-1:0]   rf_raddr,
    input  logic [XLEN-1:0] rf_rdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [AW-1:0]   out_idx,
    output logic [XLEN-1:0] out_data,
    output logic            out_last,
    output logic            busy,
    output logic            done,
    output logic            range_err
);

    state_e            state_q, state_d;
    logic [AW-1:0]     cur_q, cur_d;
    logic [AW-1:0]     end_idx_q, end_idx_d;
    logic              valid_q, valid_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [XLEN-1:0]   data_q, data_d;
    logic              last_q, last_d;
    logic              done_q, done_d;
    logic              range_err_q, range_err_d;

    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        end_idx_d   = end_idx_q;
        valid_d     = valid_q;
        idx_d       = idx_q;
        data_d      = data_q;
        last_d      = last_q;
        done_d      = 1'b0;
        range_err_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                // abort in the same cycle as start suppresses the request
                if (start && !abort) begin
                    if (first_idx <= last_idx) begin
                        cur_d     = first_idx;
                        end_idx_d = last_idx;
                        state_d   = StFetch;
                    end else begin
                        range_err_d = 1'b1;
                        done_d      = 1'b1;
                    end
                end
            end
            StFetch: begin
                data_d  = rf_rdata;
                idx_d   = cur_q;
                last_d  = (cur_q == end_idx_q);
                valid_d = 1'b1;
                state_d = StSend;
            end
            StSend: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    if (last_q) begin
                        // last word ends the walk, so cur never wraps past 31
                        done_d  = 1'b1;
                        state_d = StFinish;
                    end else begin
                        cur_d   = cur_q + AW'(1);
                        state_d = StFetch;
                    end
                end
            end
            StFinish: begin
                state_d = StIdle;
            end
        endcase

        // done is registered on entry to FINISH, so an abort there cannot retract it
        if (abort && (state_q != StIdle)) begin
            state_d = StIdle;
            valid_d = 1'b0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cur_q       <= '0;
            end_idx_q   <= '0;
            valid_q     <= 1'b0;
            idx_q       <= '0;
            data_q      <= '0;
            last_q      <= 1'b0;
            done_q      <= 1'b0;
            range_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            end_idx_q   <= end_idx_d;
            valid_q     <= valid_d;
            idx_q       <= idx_d;
            data_q      <= data_d;
            last_q      <= last_d;
            done_q      <= done_d;
            range_err_q <= range_err_d;
        end
    end

    // cur only moves on an accepted start or a transfer, so the read address is glitch-free
    assign rf_raddr  = cur_q;
    assign out_valid = valid_q;
    assign out_idx   = idx_q;
    assign out_data  = data_q;
    assign out_last  = last_q;
    assign busy      = (state_q != StIdle);
    assign done      = done_q;
    assign range_err = range_err_q;

endmodule
